// File: rtl/camera_capture.sv
// Camera byte-stream capture: pairs RGB565 bytes into pixels with line/pixel indices and frame pulses.
// Optional build macro CAM_CAPTURE_BINARIZE_EN replaces the raw pixel with a thresholded 0x0000/0xFFFF word.
module camera_capture #(
    parameter int         PIX_MAX    = 1279,
    parameter int         LINE_MAX   = 959,
    parameter logic [5:0] BIN_THRESH = 6'd32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        Cam_enable_out,
    output logic [9:0]  CamHsync_count_out,
    output logic [10:0] CamPix_count_out,
    output logic [15:0] data_out,
    output logic        frame_done,
    output logic        byte_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        WAIT_START = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    // Counters stop one past the last valid index so out-of-range pixels/lines are recognisable.
    localparam logic [10:0] PIX_SAT  = 11'(PIX_MAX + 1);
    localparam logic [9:0]  LINE_SAT = 10'(LINE_MAX + 1);

    state_t      state, state_next;
    logic        start_frame, end_frame, capture_en, byte_in, line_end;
    logic [7:0]  hi_byte;
    logic        phase, href_d, got_byte;
    logic [10:0] pix_cnt;
    logic [9:0]  line_cnt;
    logic [15:0] pixel_word, pixel_value;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_VSYNC;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        capture_en  = 1'b0;
        case (state)
            WAIT_VSYNC: if (cam_vsync) state_next = WAIT_START;
            WAIT_START: begin
                if (!cam_vsync) begin
                    state_next  = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (cam_vsync) begin
                    state_next = WAIT_START;
                    end_frame  = 1'b1;
                end else begin
                    capture_en = 1'b1;
                end
            end
            default: state_next = WAIT_VSYNC;
        endcase
    end

    assign byte_in    = capture_en && cam_href;
    assign line_end   = capture_en && !cam_href && href_d && got_byte;
    assign pixel_word = {hi_byte, cam_data};

`ifdef CAM_CAPTURE_BINARIZE_EN
    logic [7:0] luma_sum;
    assign luma_sum    = {2'b00, pixel_word[15:11], 1'b0} + {2'b00, pixel_word[10:5]}
                       + {2'b00, pixel_word[4:0], 1'b0};
    assign pixel_value = (luma_sum[7:2] >= BIN_THRESH) ? 16'hFFFF : 16'h0000;
`else
    assign pixel_value = pixel_word;
`endif

    // Cam_enable_out is a valid-only strobe (no ready): data_out and both counts are qualified
    // by it in the same cycle and hold their last value whenever it is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Cam_enable_out     <= 1'b0;
            CamHsync_count_out <= '0;
            CamPix_count_out   <= '0;
            data_out           <= '0;
            frame_done         <= 1'b0;
            byte_err           <= 1'b0;
            hi_byte            <= '0;
            phase              <= 1'b0;
            href_d             <= 1'b0;
            got_byte           <= 1'b0;
            pix_cnt            <= '0;
            line_cnt           <= '0;
        end else begin
            Cam_enable_out <= 1'b0;
            frame_done     <= end_frame;
            href_d         <= byte_in;
            if (start_frame) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                phase    <= 1'b0;
                got_byte <= 1'b0;
                byte_err <= 1'b0;
            end else if (end_frame) begin
                // A line cut short by vsync leaves any half pixel behind.
                phase    <= 1'b0;
                got_byte <= 1'b0;
            end else if (byte_in) begin
                got_byte <= 1'b1;
                if (!phase) begin
                    hi_byte <= cam_data;
                    phase   <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (pix_cnt < PIX_SAT && line_cnt < LINE_SAT) begin
                        Cam_enable_out     <= 1'b1;
                        data_out           <= pixel_value;
                        CamPix_count_out   <= pix_cnt;
                        CamHsync_count_out <= line_cnt;
                    end
                    if (pix_cnt != PIX_SAT) pix_cnt <= pix_cnt + 11'd1;
                end
            end else if (line_end) begin
                if (phase) byte_err <= 1'b1;
                if (line_cnt != LINE_SAT) line_cnt <= line_cnt + 10'd1;
                pix_cnt  <= '0;
                phase    <= 1'b0;
                got_byte <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture: a per-cycle behavioural model of the capture rules feeds an expected
// queue; a compare process checks every output each cycle, plus literal spot checks per scenario.
module tb_camera_capture;
    localparam int         PIX_MAX    = 1;
    localparam int         LINE_MAX   = 3;
    localparam logic [5:0] BIN_THRESH = 6'd32;

`ifdef CAM_CAPTURE_BINARIZE_EN
    localparam logic [15:0] L1234 = 16'h0000;
    localparam logic [15:0] L5678 = 16'h0000;
`else
    localparam logic [15:0] L1234 = 16'h1234;
    localparam logic [15:0] L5678 = 16'h5678;
`endif

    // clock / reset
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        Cam_enable_out;
    logic [9:0]  CamHsync_count_out;
    logic [10:0] CamPix_count_out;
    logic [15:0] data_out;
    logic        frame_done;
    logic        byte_err;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    camera_capture #(.PIX_MAX(PIX_MAX), .LINE_MAX(LINE_MAX), .BIN_THRESH(BIN_THRESH)) dut (
        .clk(clk), .reset_n(reset_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .Cam_enable_out(Cam_enable_out),
        .CamHsync_count_out(CamHsync_count_out), .CamPix_count_out(CamPix_count_out),
        .data_out(data_out), .frame_done(frame_done), .byte_err(byte_err), .state_dbg(state_dbg)
    );

    // scoreboard
    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    int exp_pix_q[$], exp_line_q[$], exp_cyc_q[$];
    int fd_q[$];
    logic [15:0] log_data[$];
    int log_pix[$], log_line[$];
    int fd_seen = 0;

    // behavioural model state
    bit capturing, armed, prev_hr, phase, chk_en;
    int line, pix, nbytes;
    logic [7:0] hi_b;
    logic [15:0] hold_data;
    int hold_pix, hold_line;
    bit err_old, err_new;
    int err_at;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_pixel(input logic [15:0] w);
`ifdef CAM_CAPTURE_BINARIZE_EN
        int y;
        y = (int'(w[15:11]) * 2 + int'(w[10:5]) + int'(w[4:0]) * 2) / 4;
        return (y >= int'(BIN_THRESH)) ? 16'hFFFF : 16'h0000;
`else
        return w;
`endif
    endfunction

    task automatic set_err(input bit v, input int at);
        err_old = err_new;
        err_new = v;
        err_at  = at;
    endtask

    task automatic model_reset();
        exp_q.delete(); exp_pix_q.delete(); exp_line_q.delete(); exp_cyc_q.delete();
        fd_q.delete();
        capturing = 0; armed = 0; prev_hr = 0; phase = 0;
        line = 0; pix = 0; nbytes = 0; hi_b = 8'h00;
        hold_data = 16'h0000; hold_pix = 0; hold_line = 0;
        err_old = 0; err_new = 0; err_at = 0;
    endtask

    // driver: one input cycle, and the model's view of what it must cause one cycle later
    task automatic drive(input bit vs, input bit hr, input logic [7:0] d);
        int k;
        bit was_cap;
        @(posedge clk); #1;
        cam_vsync = vs; cam_href = hr; cam_data = d;
        k = cyc;
        was_cap = capturing;
        if (!capturing) begin
            if (vs) armed = 1;
            else if (armed) begin
                capturing = 1; armed = 0;
                line = 0; pix = 0; phase = 0; nbytes = 0;
                set_err(0, k + 1);
            end
        end else if (vs) begin
            capturing = 0; armed = 1;
            fd_q.push_back(k + 1);
        end else if (hr) begin
            nbytes++;
            if (!phase) begin
                hi_b = d; phase = 1;
            end else begin
                phase = 0;
                if (pix <= PIX_MAX && line <= LINE_MAX) begin
                    exp_q.push_back(model_pixel({hi_b, d}));
                    exp_pix_q.push_back(pix);
                    exp_line_q.push_back(line);
                    exp_cyc_q.push_back(k + 1);
                end
                if (pix <= PIX_MAX) pix++;
            end
        end else if (prev_hr && nbytes > 0) begin
            if (phase) set_err(1, k + 1);
            phase = 0; pix = 0; nbytes = 0;
            if (line <= LINE_MAX) line++;
        end
        prev_hr = was_cap && !vs && hr;
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(1'b0, 1'b1, b);
    endtask

    task automatic end_line();
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_pixels(input logic [15:0] base, input int n);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = base + 16'(i);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
    endtask

    task automatic vsync_pulse();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_enable"}, Cam_enable_out, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_byte_err"}, byte_err, 0);
        check({tag, "_data"}, data_out, 16'h0000);
        check({tag, "_line"}, CamHsync_count_out, 0);
        check({tag, "_pix"}, CamPix_count_out, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_checks(tag);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // compare process: every cycle out of reset
    always @(negedge clk) begin
        bit exp_err;
        if (reset_n && chk_en) begin
            exp_err = (cyc >= err_at) ? err_new : err_old;
            if (Cam_enable_out) begin
                log_data.push_back(data_out);
                log_pix.push_back(int'(CamPix_count_out));
                log_line.push_back(int'(CamHsync_count_out));
                if (exp_q.size() == 0) begin
                    check("strobe_unexpected", Cam_enable_out, 0);
                end else begin
                    hold_data = exp_q.pop_front();
                    hold_pix  = exp_pix_q.pop_front();
                    hold_line = exp_line_q.pop_front();
                    check("strobe_cycle", cyc, exp_cyc_q.pop_front());
                    check("data", data_out, hold_data);
                    check("pix", CamPix_count_out, hold_pix);
                    check("line", CamHsync_count_out, hold_line);
                end
            end else begin
                if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
                    check("strobe_missing", Cam_enable_out, 1);
                    void'(exp_q.pop_front()); void'(exp_pix_q.pop_front());
                    void'(exp_line_q.pop_front()); void'(exp_cyc_q.pop_front());
                end
                check("hold_data", data_out, hold_data);
                check("hold_pix", CamPix_count_out, hold_pix);
                check("hold_line", CamHsync_count_out, hold_line);
            end
            if (frame_done) fd_seen++;
            if (fd_q.size() > 0 && fd_q[0] == cyc) begin
                check("frame_done", frame_done, 1);
                void'(fd_q.pop_front());
            end else begin
                check("frame_done", frame_done, 0);
            end
            check("byte_err", byte_err, exp_err);
        end
    end

    // stimulus
    initial begin
        int n0, f0;
        model_reset();
        chk_en = 0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_en = 1;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'hEE);   // href before any vsync is ignored

        // two pixels from four bytes
        vsync_pulse();
        n0 = log_data.size();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        end_line();
        check("s033_count", log_data.size() - n0, 2);
        check("s033_data0", log_data[n0], L1234);
        check("s033_pix0", log_pix[n0], 0);
        check("s033_line0", log_line[n0], 0);
        check("s033_data1", log_data[n0 + 1], L5678);
        check("s033_pix1", log_pix[n0 + 1], 1);

        // three lines of two pixels, one frame_done
        vsync_pulse();
        n0 = log_data.size();
        f0 = fd_seen;
        for (int l = 0; l < 3; l++) begin
            send_pixels(16'h0100 * 16'(l + 1), 2);
            end_line();
        end
        vsync_pulse();
        check("s034_count", log_data.size() - n0, 6);
        check("s034_line_a", log_line[n0], 0);
        check("s034_line_b", log_line[n0 + 2], 1);
        check("s034_line_c", log_line[n0 + 4], 2);
        check("s034_frames", fd_seen - f0, 1);
        check("s034_byte_err", byte_err, 0);

        // odd byte count line
        n0 = log_data.size();
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE);
        end_line();
        check("s035_byte_err", byte_err, 1);
        send_pixels(16'h1122, 1);
        end_line();
        check("s035_count", log_data.size() - n0, 2);
        check("s035_next_pix", log_pix[n0 + 1], 0);
        check("s035_next_line", log_line[n0 + 1], 1);

        // pixel index saturation, then line index saturation
        vsync_pulse();
        n0 = log_data.size();
        send_pixels(16'h2000, 3);
        end_line();
        check("s036_count", log_data.size() - n0, 2);
        check("s036_last_pix", log_pix[log_pix.size() - 1], 1);
        n0 = log_data.size();
        for (int l = 0; l < 4; l++) begin
            send_pixels(16'h3000 + 16'(l * 16), 2);
            end_line();
        end
        check("line_sat_count", log_data.size() - n0, 6);
        check("line_sat_last", log_line[log_line.size() - 1], 3);

        // vsync rising mid-line aborts without a partial pixel
        vsync_pulse();
        n0 = log_data.size();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        drive(1'b1, 1'b1, 8'hDD);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("abort_count", log_data.size() - n0, 1);

        // extreme pixel values
        n0 = log_data.size();
        send_pixels(16'hFFFF, 1);
        send_pixels(16'h0000, 1);
        end_line();
        check("s038_white", log_data[n0], 16'hFFFF);
        check("s038_black", log_data[n0 + 1], 16'h0000);

        // reset mid-line, href kept active afterwards
        send_byte(8'h55);
        do_reset("midreset");
        n0 = log_data.size();
        for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i));
        end_line();
        check("s037_no_strobe", log_data.size() - n0, 0);
        vsync_pulse();
        n0 = log_data.size();
        send_pixels(16'h4321, 1);
        end_line();
        check("s037_resume_count", log_data.size() - n0, 1);
        check("s037_resume_pix", log_pix[n0], 0);
        check("s037_resume_line", log_line[n0], 0);

        repeat (4) drive(1'b0, 1'b0, 8'h00);
        check("exp_q_drained", exp_q.size(), 0);
        check("fd_q_drained", fd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
